// File: rtl/axi_fifo_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : axi_fifo_rr_arb
// Description : Round-robin arbiter that merges NUM ready/valid requesters
//               into one registered output stage that feeds a FIFO write
//               port. A grant is held for a whole burst (through the beat
//               flagged last) when AXI_ARB_BURST_LOCK_EN is defined.
//               Otherwise the arbiter round-robins on every beat.
// Macro       : AXI_ARB_BURST_LOCK_EN (burst lock on/off)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_fifo_rr_arb #(
    parameter  int NUM = 4,
    parameter  int FDW = 32,
    localparam int IDW = $clog2(NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [NUM-1:0]     s_vld,
    output logic [NUM-1:0]     s_rdy,
    input  logic [NUM*FDW-1:0] s_data,
    input  logic [NUM-1:0]     s_last,
    output logic               m_vld,
    input  logic               m_rdy,
    output logic [FDW-1:0]     m_data,
    output logic               m_last,
    output logic [IDW-1:0]     m_id
);

    localparam logic [IDW:0]   C_NUM_EXT  = (IDW+1)'(NUM);
    localparam logic [IDW-1:0] C_LAST_IDX = IDW'(NUM-1);

`ifdef AXI_ARB_BURST_LOCK_EN
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] gnt_q, gnt_d;
`endif

    logic           m_vld_q,  m_vld_d;
    logic [FDW-1:0] m_data_q, m_data_d;
    logic           m_last_q, m_last_d;
    logic [IDW-1:0] m_id_q,   m_id_d;
    logic [IDW-1:0] ptr_q,    ptr_d;

    logic           w_free;
    logic           w_kill;
    logic           w_win_vld;
    logic [IDW-1:0] w_win_idx;
    logic [IDW:0]   w_idx_ext;
    logic           w_sel_vld;
    logic [IDW-1:0] w_sel_idx;
    logic           w_accept;
    logic [IDW-1:0] w_ptr_next;

    // Output register can take a beat when empty or draining this cycle;
    // nothing is offered while a reset/clear would discard it.
    always_comb begin
        w_free = !m_vld_q || m_rdy;
        w_kill = rst || clr;
    end

    // Round-robin search: first valid requester at or after ptr, with wrap.
    // Walking offsets from high to low lets the smallest offset win last.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_idx_ext = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            w_idx_ext = {1'b0, ptr_q} + (IDW+1)'(k);
            if (w_idx_ext >= C_NUM_EXT) begin
                w_idx_ext = w_idx_ext - C_NUM_EXT;
            end
            if (s_vld[w_idx_ext[IDW-1:0]]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_idx_ext[IDW-1:0];
            end
        end
    end

    // Choose the serviced requester and drive the one-hot ready vector.
    always_comb begin
`ifdef AXI_ARB_BURST_LOCK_EN
        if (state_q == ST_BURST) begin
            w_sel_idx = gnt_q;
            w_sel_vld = s_vld[gnt_q];
        end else begin
            w_sel_idx = w_win_idx;
            w_sel_vld = w_win_vld;
        end
`else
        w_sel_idx = w_win_idx;
        w_sel_vld = w_win_vld;
`endif
        s_rdy = '0;
`ifdef AXI_ARB_BURST_LOCK_EN
        // A held grant keeps ready on its owner even while it stalls.
        if (state_q == ST_BURST) begin
            s_rdy[gnt_q] = w_free && !w_kill;
        end else if (w_win_vld) begin
            s_rdy[w_win_idx] = w_free && !w_kill;
        end
`else
        if (w_win_vld) begin
            s_rdy[w_win_idx] = w_free && !w_kill;
        end
`endif
        w_accept   = w_sel_vld && w_free && !w_kill;
        w_ptr_next = (w_sel_idx == C_LAST_IDX) ? '0 : w_sel_idx + 1'b1;
    end

    // Next-state: load the output stage on a handshake, drain it otherwise.
    always_comb begin
        m_vld_d  = m_vld_q;
        m_data_d = m_data_q;
        m_last_d = m_last_q;
        m_id_d   = m_id_q;
        ptr_d    = ptr_q;
`ifdef AXI_ARB_BURST_LOCK_EN
        state_d  = state_q;
        gnt_d    = gnt_q;
`endif
        if (w_accept) begin
            m_vld_d  = 1'b1;
            m_data_d = s_data[w_sel_idx*FDW +: FDW];
            m_last_d = s_last[w_sel_idx];
            m_id_d   = w_sel_idx;
`ifdef AXI_ARB_BURST_LOCK_EN
            if (s_last[w_sel_idx]) begin
                state_d = ST_IDLE;
                ptr_d   = w_ptr_next;
            end else begin
                state_d = ST_BURST;
                gnt_d   = w_sel_idx;
            end
`else
            ptr_d    = w_ptr_next;
`endif
        end else if (m_rdy) begin
            m_vld_d = 1'b0;
        end
    end

    // State register; rst and clr both return to the idle, empty state.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            m_vld_q  <= 1'b0;
            m_data_q <= '0;
            m_last_q <= 1'b0;
            m_id_q   <= '0;
            ptr_q    <= '0;
`ifdef AXI_ARB_BURST_LOCK_EN
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
`endif
        end else begin
            m_vld_q  <= m_vld_d;
            m_data_q <= m_data_d;
            m_last_q <= m_last_d;
            m_id_q   <= m_id_d;
            ptr_q    <= ptr_d;
`ifdef AXI_ARB_BURST_LOCK_EN
            state_q  <= state_d;
            gnt_q    <= gnt_d;
`endif
        end
    end

    assign m_vld  = m_vld_q;
    assign m_data = m_data_q;
    assign m_last = m_last_q;
    assign m_id   = m_id_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_fifo_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_fifo_rr_arb
// Description : Self-checking bench for axi_fifo_rr_arb (NUM=4, FDW=32) with
//               a behavioural reference model; follows AXI_ARB_BURST_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_fifo_rr_arb;

    localparam int NUM = 4;
    localparam int FDW = 32;
    localparam int IDW = $clog2(NUM);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clr = 1'b0;
    logic [NUM-1:0]     s_vld = '0;
    logic [NUM-1:0]     s_rdy;
    logic [NUM*FDW-1:0] s_data = '0;
    logic [NUM-1:0]     s_last = '0;
    logic               m_vld;
    logic               m_rdy = 1'b1;
    logic [FDW-1:0]     m_data;
    logic               m_last;
    logic [IDW-1:0]     m_id;

    axi_fifo_rr_arb #(.NUM(NUM), .FDW(FDW)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .s_vld  (s_vld),
        .s_rdy  (s_rdy),
        .s_data (s_data),
        .s_last (s_last),
        .m_vld  (m_vld),
        .m_rdy  (m_rdy),
        .m_data (m_data),
        .m_last (m_last),
        .m_id   (m_id)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: pointer, burst owner (-1 = none), output stage.
    int             mdl_ptr  = 0;
    int             mdl_own  = -1;
    logic           mdl_vld  = 1'b0;
    logic [FDW-1:0] mdl_data = '0;
    logic           mdl_last = 1'b0;
    int             mdl_id   = 0;

    logic [NUM-1:0] obs_rdy;
    int             ids_q[$];
    int             exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM*FDW-1:0] rand_data();
        logic [NUM*FDW-1:0] d;
        for (int i = 0; i < NUM; i++) d[i*FDW +: FDW] = $urandom;
        return d;
    endfunction

    // One clock: drive inputs, compare ready against the model, step the
    // model on the edge, then compare the output stage.
    task automatic cycle(input logic [NUM-1:0] v, input logic [NUM*FDW-1:0] d,
                         input logic [NUM-1:0] l, input logic mr,
                         input logic r, input logic c);
        int             g;
        logic           fr;
        logic           kill;
        logic [NUM-1:0] er;
        @(negedge clk);
        s_vld = v; s_data = d; s_last = l; m_rdy = mr; rst = r; clr = c;
        #1;
        fr   = !mdl_vld || mr;
        kill = r || c;
        g    = -1;
        if (mdl_own >= 0) begin
            g = mdl_own;
        end else begin
            for (int k = 0; k < NUM; k++)
                if (g < 0 && v[(mdl_ptr + k) % NUM]) g = (mdl_ptr + k) % NUM;
        end
        er = '0;
        if (!kill && g >= 0) er[g] = fr;
        obs_rdy = s_rdy;
        check("s_rdy", s_rdy, er);
        @(posedge clk);
        if (kill) begin
            mdl_ptr = 0; mdl_own = -1; mdl_vld = 0; mdl_data = '0; mdl_last = 0; mdl_id = 0;
        end else if (g >= 0 && v[g] && fr) begin
            mdl_vld  = 1'b1;
            mdl_data = d[g*FDW +: FDW];
            mdl_last = l[g];
            mdl_id   = g;
`ifdef AXI_ARB_BURST_LOCK_EN
            if (l[g]) begin
                mdl_own = -1;
                mdl_ptr = (g + 1) % NUM;
            end else begin
                mdl_own = g;
            end
`else
            mdl_ptr = (g + 1) % NUM;
`endif
        end else if (mr) begin
            mdl_vld = 1'b0;
        end
        #1;
        check("m_vld", m_vld, mdl_vld);
        check("m_data", m_data, mdl_data);
        check("m_last", m_last, mdl_last);
        check("m_id", m_id, mdl_id);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle('1, rand_data(), '0, 1'b1, 1'b1, 1'b0);
            check("rst_rdy", obs_rdy, 0);
            check("rst_mvld", m_vld, 0);
        end
    endtask

    // Requesters issue bursts of the given lengths; ids of output beats are logged.
    task automatic run_bursts(input int l0, input int l1, input int l2, input int l3,
                              input bit all_last);
        int             rem[NUM];
        int             total;
        logic [NUM-1:0] v, l;
        rem[0] = l0; rem[1] = l1; rem[2] = l2; rem[3] = l3;
        total = l0 + l1 + l2 + l3;
        for (int n = 0; n < 60 && total > 0; n++) begin
            for (int i = 0; i < NUM; i++) begin
                v[i] = rem[i] > 0;
                l[i] = all_last || rem[i] == 1;
            end
            cycle(v, rand_data(), l, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < NUM; i++)
                if (obs_rdy[i] && v[i]) begin
                    rem[i]--;
                    total--;
                end
            if (m_vld) ids_q.push_back(int'(m_id));
        end
        check("burst_done", total, 0);
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_len"}, ids_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < ids_q.size(); i++)
            check(tag, ids_q[i], exp_q[i]);
    endtask

    initial begin
        logic [NUM*FDW-1:0] d;

        // Reset with all requesters valid, then first grant goes to req0.
        do_reset();
        cycle(4'b0001, rand_data(), 4'b0001, 1'b1, 1'b0, 1'b0);
        check("rst_release_rdy", obs_rdy, 4'b0001);

        // Long burst from req0 competing with req1.
        do_reset();
        ids_q.delete();
        run_bursts(4, 1, 0, 0, 1'b0);
`ifdef AXI_ARB_BURST_LOCK_EN
        exp_q = '{0, 0, 0, 0, 1};
`else
        exp_q = '{0, 1, 0, 0, 0};
`endif
        check_seq("seq_lock4");

        // Two 3-beat bursts from req0 and req1.
        do_reset();
        ids_q.delete();
        run_bursts(3, 3, 0, 0, 1'b0);
`ifdef AXI_ARB_BURST_LOCK_EN
        exp_q = '{0, 0, 0, 1, 1, 1};
`else
        exp_q = '{0, 1, 0, 1, 0, 1};
`endif
        check_seq("seq_3x2");

        // Round-robin wrap starting from ptr = 3.
        do_reset();
        run_bursts(0, 0, 1, 0, 1'b1);
        ids_q.delete();
        run_bursts(1, 1, 1, 2, 1'b1);
        exp_q = '{3, 0, 1, 2, 3};
        check_seq("rr_wrap");

        // Back-pressure: output held stable, all readies low.
        do_reset();
        d = rand_data();
        d[0 +: FDW] = 32'hA5A5A5A5;
        cycle(4'b0001, d, 4'b0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle('1, rand_data(), 4'($urandom), 1'b0, 1'b0, 1'b0);
            check("bp_rdy", obs_rdy, 0);
            check("bp_vld", m_vld, 1);
            check("bp_data", m_data, 32'hA5A5A5A5);
        end
        d = rand_data();
        d[FDW +: FDW] = 32'h5A5A0001;
        cycle('1, d, '1, 1'b1, 1'b0, 1'b0);
        check("bp_resume_rdy", obs_rdy, 4'b0010);
        check("bp_resume_id", m_id, 1);
        check("bp_resume_data", m_data, 32'h5A5A0001);

        // Clear in the middle of a req2 burst.
        do_reset();
        cycle(4'b0100, rand_data(), '0, 1'b1, 1'b0, 1'b0);
        cycle(4'b0100, rand_data(), '0, 1'b1, 1'b0, 1'b0);
        cycle(4'b1100, rand_data(), '0, 1'b1, 1'b0, 1'b1);
        check("clr_rdy", obs_rdy, 0);
        check("clr_mvld", m_vld, 0);
        cycle(4'b1100, rand_data(), '0, 1'b1, 1'b0, 1'b0);
        check("clr_winner", obs_rdy, 4'b0100);

        // Randomised traffic with occasional clears and back-pressure.
        for (int n = 0; n < 600; n++) begin
            cycle(4'($urandom), rand_data(), 4'($urandom & $urandom),
                  ($urandom_range(0, 3) != 0), 1'b0, ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
